// File: rtl/player_input_conditioner_pkg.sv
// Shared definitions for the player pad conditioner: quadrature encodings,
// default timing constants and the clockwise-successor helper.
package player_input_conditioner_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES  = 32000;
  localparam int unsigned DEFAULT_STEPS_PER_DETENT = 4;
  localparam int unsigned NUM_LINES                = 5;

  // {A,B} levels of one encoder; clockwise order is Q00->Q01->Q11->Q10->Q00
  typedef enum logic [1:0] {
    Q00 = 2'b00,
    Q01 = 2'b01,
    Q11 = 2'b11,
    Q10 = 2'b10
  } quad_t;

  function automatic quad_t quad_cw(input quad_t q);
    case (q)
      Q00:     return Q01;
      Q01:     return Q11;
      Q11:     return Q10;
      default: return Q00;
    endcase
  endfunction

endpackage

// File: rtl/player_input_conditioner_if.sv
// Raw player pads in, conditioned single-cycle paddle/start/error pulses out.
interface player_input_conditioner_if;

  logic player1_a;
  logic player1_b;
  logic player2_a;
  logic player2_b;
  logic start;
  logic p1_up;
  logic p1_down;
  logic p2_up;
  logic p2_down;
  logic start_pulse;
  logic quad_err;

  modport master (
    output player1_a, player1_b, player2_a, player2_b, start,
    input  p1_up, p1_down, p2_up, p2_down, start_pulse, quad_err
  );

  modport slave (
    input  player1_a, player1_b, player2_a, player2_b, start,
    output p1_up, p1_down, p2_up, p2_down, start_pulse, quad_err
  );

endinterface

// File: rtl/player_input_conditioner_debounce_line.sv
// One pad line: two-flop synchroniser followed by a hold-time debounce that
// only accepts a new level after it has been stable for DEBOUNCE_CYCLES samples.
module player_input_conditioner_debounce_line
  import player_input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad,
  output logic level
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level_q;
  logic [CNT_W-1:0] cnt;

  // Any sample matching the accepted level restarts the hold window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1 <= pad;
      sync2 <= sync1;
      if (sync2 == level_q) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level_q <= sync2;
        cnt     <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign level = level_q;

endmodule

// File: rtl/player_input_conditioner_quad_decoder.sv
// Quadrature decoder for one rotary encoder: signed step accumulator that
// emits one up/down pulse per full detent and flags illegal double-bit jumps.
module player_input_conditioner_quad_decoder
  import player_input_conditioner_pkg::*;
#(
  parameter int unsigned STEPS_PER_DETENT = DEFAULT_STEPS_PER_DETENT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  output logic up,
  output logic down,
  output logic err
);

  localparam int unsigned ACC_W = $clog2(STEPS_PER_DETENT) + 2;
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(STEPS_PER_DETENT);
  localparam logic signed [ACC_W-1:0] ACC_MIN = -ACC_MAX;

  quad_t                   cur;
  quad_t                   prev;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_base_c;
  logic signed [ACC_W-1:0] acc_next_c;
  logic                    fwd_c;
  logic                    rev_c;
  logic                    bad_c;
  logic                    hit_up_c;
  logic                    hit_dn_c;

  assign cur = quad_t'({a, b});

  // Classify the move; a full detent empties the accumulator as it is reported
  always_comb begin
    fwd_c      = 1'b0;
    rev_c      = 1'b0;
    bad_c      = 1'b0;
    hit_up_c   = (acc == ACC_MAX);
    hit_dn_c   = (acc == ACC_MIN);
    acc_base_c = (hit_up_c || hit_dn_c) ? '0 : acc;
    if (cur != prev) begin
      if (cur == quad_cw(prev)) begin
        fwd_c = 1'b1;
      end else if (prev == quad_cw(cur)) begin
        rev_c = 1'b1;
      end else begin
        bad_c = 1'b1;
      end
    end
    acc_next_c = acc_base_c;
    if (fwd_c) begin
      acc_next_c = acc_base_c + ACC_W'(1);
    end else if (rev_c) begin
      acc_next_c = acc_base_c - ACC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= Q00;
      acc  <= '0;
      up   <= 1'b0;
      down <= 1'b0;
      err  <= 1'b0;
    end else begin
      prev <= cur;
      acc  <= acc_next_c;
      up   <= hit_up_c;
      down <= hit_dn_c;
      err  <= bad_c;
    end
  end

endmodule

// File: rtl/player_input_conditioner.sv
// Pad conditioner between the board pins and the pong core: debounces all five
// pads, decodes both encoders and reduces the start button to a press pulse.
module player_input_conditioner
  import player_input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES  = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned STEPS_PER_DETENT = DEFAULT_STEPS_PER_DETENT,
  parameter bit          REVERSE_P2       = 1'b0
) (
  input logic                        clk32mhz,
  input logic                        reset_n,
  player_input_conditioner_if.slave  pads
);

  localparam int unsigned LINE_P1A   = 0;
  localparam int unsigned LINE_P1B   = 1;
  localparam int unsigned LINE_P2A   = 2;
  localparam int unsigned LINE_P2B   = 3;
  localparam int unsigned LINE_START = 4;

  logic [NUM_LINES-1:0] raw;
  logic [NUM_LINES-1:0] lvl;
  logic                 p1_up_q;
  logic                 p1_dn_q;
  logic                 p2_up_q;
  logic                 p2_dn_q;
  logic                 p1_err_q;
  logic                 p2_err_q;
  logic                 start_d;
  logic                 start_q;
  logic                 start_pulse_q;
  logic                 quad_err_q;

  assign raw = {pads.start, pads.player2_b, pads.player2_a, pads.player1_b, pads.player1_a};

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_db
    player_input_conditioner_debounce_line #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk32mhz),
      .rst_n (reset_n),
      .pad   (raw[i]),
      .level (lvl[i])
    );
  end

  player_input_conditioner_quad_decoder #(
    .STEPS_PER_DETENT (STEPS_PER_DETENT)
  ) u_quad_p1 (
    .clk   (clk32mhz),
    .rst_n (reset_n),
    .a     (lvl[LINE_P1A]),
    .b     (lvl[LINE_P1B]),
    .up    (p1_up_q),
    .down  (p1_dn_q),
    .err   (p1_err_q)
  );

  player_input_conditioner_quad_decoder #(
    .STEPS_PER_DETENT (STEPS_PER_DETENT)
  ) u_quad_p2 (
    .clk   (clk32mhz),
    .rst_n (reset_n),
    .a     (lvl[LINE_P2A]),
    .b     (lvl[LINE_P2B]),
    .up    (p2_up_q),
    .down  (p2_dn_q),
    .err   (p2_err_q)
  );

  // Start edge detect is delayed one stage so it lines up with paddle pulses
  always_ff @(posedge clk32mhz or negedge reset_n) begin
    if (!reset_n) begin
      start_d       <= 1'b0;
      start_q       <= 1'b0;
      start_pulse_q <= 1'b0;
      quad_err_q    <= 1'b0;
    end else begin
      start_d       <= lvl[LINE_START];
      start_q       <= start_d;
      start_pulse_q <= start_d & ~start_q;
      quad_err_q    <= p1_err_q | p2_err_q;
    end
  end

  assign pads.p1_up       = p1_up_q;
  assign pads.p1_down     = p1_dn_q;
  assign pads.p2_up       = REVERSE_P2 ? p2_dn_q : p2_up_q;
  assign pads.p2_down     = REVERSE_P2 ? p2_up_q : p2_dn_q;
  assign pads.start_pulse = start_pulse_q;
  assign pads.quad_err    = quad_err_q;

endmodule
